fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit_pc_counter.sv | 36 +++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared opcode definitions: opcode/addressing-mode encodings and the
// instruction-word field layout used by the fetch path.
package fetch_unit_pkg;

  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 8;
  localparam int unsigned MODE_MSB = 7;
  localparam int unsigned MODE_LSB = 0;

  typedef enum logic [7:0] {
    OP_NOP = 8'h00,
    LDS    = 8'h10,
    COM    = 8'h20,
    BA     = 8'h30
  } opcode_e;

  typedef enum logic [7:0] {
    INHERENT    = 8'h00,
    IMMEDIATE   = 8'h01,
    DIRECT      = 8'h02,
    PC_RELATIVE = 8'h03,
    INDEXED     = 8'h04
  } amode_e;

  function automatic logic is_inherent(input logic [15:0] word);
    return word[MODE_MSB:MODE_LSB] == INHERENT;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter with synchronous load and modulo-2^ADDR_W increment.
module pc_counter #(
  parameter int unsigned           ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads an opcode word and, unless INHERENT, an operand
// word, then presents the bundle until the consumer accepts it.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              nReset,
  output logic [ADDR_W-1:0] address,
  input  logic [15:0]       data,
  output logic              write,
  input  logic              bus_grant,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr_word,
  output logic [15:0]       instr_operand,
  output logic              instr_has_operand,
  output logic [ADDR_W-1:0] instr_pc
);

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_ARG,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       word_q, word_d;
  logic [15:0]       oper_q, oper_d;
  logic              has_q, has_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [ADDR_W-1:0] pc;
  logic              pc_load;
  logic              pc_inc;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock    (clock),
    .nReset   (nReset),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (redirect_pc),
    .pc       (pc)
  );

  // Redirect wins everywhere; a HOLD-state handshake in the same cycle also
  // lands in FETCH_OP, so it completes without extra logic.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    oper_d  = oper_q;
    has_d   = has_q;
    ipc_d   = ipc_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    if (redirect) begin
      state_d = FETCH_OP;
      pc_load = 1'b1;
    end else begin
      case (state_q)
        FETCH_OP: begin
          if (bus_grant) begin
            word_d = data;
            ipc_d  = pc;
            pc_inc = 1'b1;
            if (is_inherent(data)) begin
              oper_d  = '0;
              has_d   = 1'b0;
              state_d = HOLD;
            end else begin
              has_d   = 1'b1;
              state_d = FETCH_ARG;
            end
          end
        end
        FETCH_ARG: begin
          if (bus_grant) begin
            oper_d  = data;
            pc_inc  = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            state_d = FETCH_OP;
          end
        end
        default: state_d = FETCH_OP;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= FETCH_OP;
      word_q  <= '0;
      oper_q  <= '0;
      has_q   <= 1'b0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      oper_q  <= oper_d;
      has_q   <= has_d;
      ipc_q   <= ipc_d;
    end
  end

  assign address           = pc;
  assign write             = 1'b0;
  assign instr_valid       = (state_q == HOLD);
  assign instr_word        = word_q;
  assign instr_operand     = oper_q;
  assign instr_has_operand = has_q;
  assign instr_pc          = ipc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational memory model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic [15:0] address;
  logic [15:0] data;
  logic        write;
  logic        bus_grant = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_word;
  logic [15:0] instr_operand;
  logic        instr_has_operand;
  logic [15:0] instr_pc;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:65535];
  logic [49:0] bnd;

  assign data = mem[address];
  assign bnd  = {instr_valid, instr_has_operand, instr_word, instr_operand, instr_pc};

  always #5 clock = ~clock;

  fetch_unit #(
    .ADDR_W   (16),
    .RESET_PC (16'd0)
  ) dut (
    .clock             (clock),
    .nReset            (nReset),
    .address           (address),
    .data              (data),
    .write             (write),
    .bus_grant         (bus_grant),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .instr_word        (instr_word),
    .instr_operand     (instr_operand),
    .instr_has_operand (instr_has_operand),
    .instr_pc          (instr_pc)
  );

  task automatic goto(input logic [15:0] a);
    @(negedge clock);
    redirect    = 1'b1;
    redirect_pc = a;
    bus_grant   = 1'b0;
    @(negedge clock);
    redirect    = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if (bnd !== 50'd0) begin
      failures++; $display("FAIL reset_bundle act=%h exp=%h", bnd, 50'd0);
    end
    checks++;
    if (address !== 16'd0) begin
      failures++; $display("FAIL reset_address act=%h exp=%h", address, 16'd0);
    end
    checks++;
    if (write !== 1'b0) begin
      failures++; $display("FAIL reset_write act=%b exp=0", write);
    end
  endtask

  task automatic test_immediate();
    nReset = 1'b1; bus_grant = 1'b1; instr_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({instr_valid, address} !== {1'b0, 16'd1}) begin
      failures++; $display("FAIL imm_arg act=%b/%h exp=0/0001", instr_valid, address);
    end
    @(negedge clock);
    checks++;
    if (bnd !== {1'b1, 1'b1, 16'h1001, 16'd500, 16'd0}) begin
      failures++; $display("FAIL imm_bundle act=%h exp=%h", bnd, {1'b1, 1'b1, 16'h1001, 16'd500, 16'd0});
    end
    @(negedge clock);
    checks++;
    if ({instr_valid, address} !== {1'b0, 16'd2}) begin
      failures++; $display("FAIL imm_next act=%b/%h exp=0/0002", instr_valid, address);
    end
    bus_grant = 1'b0;
  endtask

  task automatic test_inherent();
    goto(16'd16);
    bus_grant = 1'b1; instr_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (bnd !== {1'b1, 1'b0, 16'h2000, 16'd0, 16'd16}) begin
      failures++; $display("FAIL inh_bundle act=%h exp=%h", bnd, {1'b1, 1'b0, 16'h2000, 16'd0, 16'd16});
    end
    checks++;
    if (address !== 16'd17) begin
      failures++; $display("FAIL inh_pc act=%h exp=0011", address);
    end
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if ({bnd, address} !== {1'b1, 1'b0, 16'h2000, 16'd0, 16'd16, 16'd17}) begin
        failures++; $display("FAIL stall_%0d act=%h/%h exp=stable bundle, pc 0011", i, bnd, address);
      end
    end
    bus_grant = 1'b0; instr_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({instr_valid, address} !== {1'b0, 16'd17}) begin
      failures++; $display("FAIL stall_release act=%b/%h exp=0/0011", instr_valid, address);
    end
  endtask

  task automatic test_redirect();
    goto(16'd40);
    bus_grant = 1'b1; instr_ready = 1'b0;
    @(negedge clock);
    checks++;
    if ({instr_valid, address} !== {1'b0, 16'd41}) begin
      failures++; $display("FAIL redir_arg act=%b/%h exp=0/0029", instr_valid, address);
    end
    redirect = 1'b1; redirect_pc = 16'd99;
    @(negedge clock);
    checks++;
    if ({instr_valid, address, instr_operand} !== {1'b0, 16'd99, 16'd0}) begin
      failures++; $display("FAIL redir_drop act=%b/%h/%h exp=0/0063/0000", instr_valid, address, instr_operand);
    end
    redirect = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({bnd, address} !== {1'b1, 1'b1, 16'h3003, 16'hFFFF, 16'd99, 16'd101}) begin
      failures++; $display("FAIL redir_ba act=%h/%h exp=%h/0065", bnd, address, {1'b1, 1'b1, 16'h3003, 16'hFFFF, 16'd99});
    end
    for (int i = 0; i < 3; i++) begin
      redirect = 1'b1; redirect_pc = 16'd99; instr_ready = 1'b1;
      @(negedge clock);
      checks++;
      if ({instr_valid, address} !== {1'b0, 16'd99}) begin
        failures++; $display("FAIL loop_redir_%0d act=%b/%h exp=0/0063", i, instr_valid, address);
      end
      redirect = 1'b0; instr_ready = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if ({bnd, address} !== {1'b1, 1'b1, 16'h3003, 16'hFFFF, 16'd99, 16'd101}) begin
        failures++; $display("FAIL loop_ba_%0d act=%h/%h exp=%h/0065", i, bnd, address, {1'b1, 1'b1, 16'h3003, 16'hFFFF, 16'd99});
      end
    end
  endtask

  task automatic test_wrap();
    goto(16'hFFFF);
    bus_grant = 1'b1; instr_ready = 1'b0;
    @(negedge clock);
    checks++;
    if ({bnd, address} !== {1'b1, 1'b0, 16'h2000, 16'd0, 16'hFFFF, 16'd0}) begin
      failures++; $display("FAIL wrap act=%h/%h exp=%h/0000", bnd, address, {1'b1, 1'b0, 16'h2000, 16'd0, 16'hFFFF});
    end
    bus_grant = 1'b0; instr_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({instr_valid, address} !== {1'b0, 16'd0}) begin
      failures++; $display("FAIL wrap_release act=%b/%h exp=0/0000", instr_valid, address);
    end
  endtask

  task automatic test_grant_toggle();
    logic [15:0] exp_addr [0:7];
    logic [7:0]  exp_valid;
    exp_addr  = '{16'd200, 16'd201, 16'd201, 16'd202, 16'd202, 16'd203, 16'd203, 16'd204};
    exp_valid = 8'b1010_1000;
    goto(16'd200);
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_grant = (i % 2 == 1);
      @(negedge clock);
      checks++;
      if ({instr_valid, address} !== {exp_valid[i], exp_addr[i]}) begin
        failures++; $display("FAIL grant_%0d act=%b/%h exp=%b/%h", i, instr_valid, address, exp_valid[i], exp_addr[i]);
      end
      if (i == 3) begin
        checks++;
        if (instr_operand !== 16'h0ABC) begin
          failures++; $display("FAIL grant_operand act=%h exp=0abc", instr_operand);
        end
      end
    end
    bus_grant = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    goto(16'd300);
    bus_grant = 1'b1; instr_ready = 1'b0;
    @(negedge clock);
    checks++;
    if ({instr_valid, address} !== {1'b0, 16'd301}) begin
      failures++; $display("FAIL areset_arg act=%b/%h exp=0/012d", instr_valid, address);
    end
    #2 nReset = 1'b0;
    #1;
    checks++;
    if ({bnd, address} !== 66'd0) begin
      failures++; $display("FAIL areset_async act=%h/%h exp=0/0000", bnd, address);
    end
    @(negedge clock);
    nReset = 1'b1; bus_grant = 1'b1; instr_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({instr_valid, address} !== {1'b0, 16'd1}) begin
      failures++; $display("FAIL areset_restart act=%b/%h exp=0/0001", instr_valid, address);
    end
    @(negedge clock);
    checks++;
    if (bnd !== {1'b1, 1'b1, 16'h1001, 16'd500, 16'd0}) begin
      failures++; $display("FAIL areset_bundle act=%h exp=%h", bnd, {1'b1, 1'b1, 16'h1001, 16'd500, 16'd0});
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[0]       = 16'h1001;
    mem[1]       = 16'd500;
    mem[2]       = 16'h2000;
    mem[16]      = 16'h2000;
    mem[17]      = 16'h1001;
    mem[40]      = 16'h1001;
    mem[41]      = 16'd1234;
    mem[99]      = 16'h3003;
    mem[100]     = 16'hFFFF;
    mem[200]     = 16'h1002;
    mem[201]     = 16'h0ABC;
    mem[202]     = 16'h2000;
    mem[203]     = 16'h2000;
    mem[300]     = 16'h1001;
    mem[301]     = 16'h7777;
    mem[16'hFFFF] = 16'h2000;

    test_reset();
    test_immediate();
    test_inherent();
    test_hold_stall();
    test_redirect();
    test_wrap();
    test_grant_toggle();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
